alu_stim_sequencer: RTL and testbench

- Clocked stimulus source for the 6-bit ALU; takes the place of the switches on the board.
- Walks a fixed-length vector list and drives A, B and fxn into the ALU.
- Waits a settle window, then captures answer/carry/overflow and holds them on the LEDs for a visible period.
- Folds every captured result into an 8-bit signature, so a single value confirms the whole run on hardware or in simulation.

---
 rtl/alu_stim_sequencer.sv | 141 ++++++++++++++
 tb/tb_alu_stim_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_stim_sequencer.sv
// Clocked stimulus source for the 6-bit ALU: walks an LFSR-generated vector list,
// captures each ALU result onto the LEDs and folds it into an 8-bit signature.
module alu_stim_sequencer #(
    parameter logic [11:0] SEED          = 12'hACE,
    parameter int          NUM_VEC       = 64,
    parameter int          SETTLE_CYCLES = 4,
    parameter int          HOLD_CYCLES   = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [5:0] answer,
    input  logic       carry,
    input  logic       o_flow,
    output logic [5:0] x,
    output logic [5:0] y,
    output logic [2:0] fxn,
    output logic [5:0] led_result,
    output logic       led_carry,
    output logic       led_oflow,
    output logic       busy,
    output logic       done,
    output logic [7:0] vec_idx,
    output logic [7:0] sig
);

    // An all-zero seed would lock the LFSR, so it is quietly replaced.
    localparam logic [11:0] SEED_EFF    = (SEED == 12'h000) ? 12'h001 : SEED;
    localparam logic [26:0] SETTLE_LAST = 27'(SETTLE_CYCLES - 1);
    localparam logic [26:0] HOLD_LAST   = 27'(HOLD_CYCLES - 1);
    localparam logic [7:0]  LAST_VEC    = 8'(NUM_VEC - 1);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        CAPTURE,
        HOLD,
        NEXT,
        DONE
    } state_t;

    state_t      state, state_nx;
    logic [11:0] lfsr, lfsr_nx;
    logic [26:0] count, count_nx;
    logic [7:0]  sig_nx, vec_idx_nx;
    logic [5:0]  led_result_nx;
    logic        led_carry_nx, led_oflow_nx;
    logic        start_q;
    logic        rise;

    assign rise = start & ~start_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lfsr       <= SEED_EFF;
            count      <= 27'd0;
            vec_idx    <= 8'd0;
            sig        <= 8'h00;
            led_result <= 6'd0;
            led_carry  <= 1'b0;
            led_oflow  <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            state      <= state_nx;
            lfsr       <= lfsr_nx;
            count      <= count_nx;
            vec_idx    <= vec_idx_nx;
            sig        <= sig_nx;
            led_result <= led_result_nx;
            led_carry  <= led_carry_nx;
            led_oflow  <= led_oflow_nx;
            start_q    <= start;
        end
    end

    always_comb begin
        state_nx      = state;
        lfsr_nx       = lfsr;
        count_nx      = count;
        vec_idx_nx    = vec_idx;
        sig_nx        = sig;
        led_result_nx = led_result;
        led_carry_nx  = led_carry;
        led_oflow_nx  = led_oflow;

        case (state)
            // A finished run restarts exactly like a fresh one from IDLE.
            IDLE, DONE: begin
                if (rise) begin
                    state_nx   = DRIVE;
                    count_nx   = 27'd0;
                    sig_nx     = 8'h00;
                    vec_idx_nx = 8'd0;
                    lfsr_nx    = SEED_EFF;
                end
            end
            DRIVE: begin
                if (count == SETTLE_LAST) begin
                    count_nx = 27'd0;
                    state_nx = CAPTURE;
                end else begin
                    count_nx = count + 27'd1;
                end
            end
            CAPTURE: begin
                led_result_nx = answer;
                led_carry_nx  = carry;
                led_oflow_nx  = o_flow;
                sig_nx        = {sig[6:0], sig[7]} ^ {carry, o_flow, answer};
                state_nx      = HOLD;
            end
            HOLD: begin
                if (count == HOLD_LAST) begin
                    count_nx = 27'd0;
                    state_nx = NEXT;
                end else begin
                    count_nx = count + 27'd1;
                end
            end
            // The last vector leaves LFSR and index untouched so they can be read back.
            NEXT: begin
                if (vec_idx == LAST_VEC) begin
                    state_nx = DONE;
                end else begin
                    vec_idx_nx = vec_idx + 8'd1;
                    lfsr_nx    = {lfsr[10:0], lfsr[11] ^ lfsr[5] ^ lfsr[3] ^ lfsr[0]};
                    state_nx   = DRIVE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign x    = lfsr[11:6];
    assign y    = lfsr[5:0];
    assign fxn  = vec_idx[2:0];
    assign busy = (state == DRIVE) || (state == CAPTURE) || (state == HOLD) || (state == NEXT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_alu_stim_sequencer.sv
// Self-checking bench for alu_stim_sequencer: an adder ALU model feeds the DUT and a
// vector-level reference model predicts operands, LED captures, timing and signature.
module tb_alu_stim_sequencer;

    localparam logic [11:0] SEED   = 12'hACE;
    localparam int          S      = 4;
    localparam int          H      = 3;
    localparam int          NV     = 8;
    localparam int          PERIOD = S + 1 + H + 1;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;

    logic [5:0] answer, x, y, led_result;
    logic [2:0] fxn;
    logic       carry, o_flow, led_carry, led_oflow, busy, done;
    logic [7:0] vec_idx, sig;

    logic [5:0] answer1, x1, y1, led_result1;
    logic [2:0] fxn1;
    logic       carry1, o_flow1, led_carry1, led_oflow1, busy1, done1;
    logic [7:0] vec_idx1, sig1;

    int         nChecks = 0;
    int         nPass   = 0;
    int         dipAt;
    int         pw;
    logic [7:0] sigRun1, sigRun2;
    logic [11:0] seedV;

    alu_stim_sequencer #(.SEED(SEED), .NUM_VEC(NV), .SETTLE_CYCLES(S), .HOLD_CYCLES(H)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .answer(answer), .carry(carry), .o_flow(o_flow),
        .x(x), .y(y), .fxn(fxn), .led_result(led_result), .led_carry(led_carry),
        .led_oflow(led_oflow), .busy(busy), .done(done), .vec_idx(vec_idx), .sig(sig)
    );

    alu_stim_sequencer #(.SEED(SEED), .NUM_VEC(1), .SETTLE_CYCLES(S), .HOLD_CYCLES(H)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .answer(answer1), .carry(carry1), .o_flow(o_flow1),
        .x(x1), .y(y1), .fxn(fxn1), .led_result(led_result1), .led_carry(led_carry1),
        .led_oflow(led_oflow1), .busy(busy1), .done(done1), .vec_idx(vec_idx1), .sig(sig1)
    );

    // Board-side ALU stand-in: a plain 6-bit adder with carry and signed overflow.
    assign {carry, answer}   = {1'b0, x} + {1'b0, y};
    assign o_flow            = (x[5] == y[5]) && (answer[5] != x[5]);
    assign {carry1, answer1} = {1'b0, x1} + {1'b0, y1};
    assign o_flow1           = (x1[5] == y1[5]) && (answer1[5] != x1[5]);

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs === exp) nPass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Taps 11,5,3,0 (x^12+x^6+x^4+x+1); after 12'hACE this yields 12'h59C.
    function automatic logic [11:0] lfsrStep(input logic [11:0] v);
        return {v[10:0], v[11] ^ v[5] ^ v[3] ^ v[0]};
    endfunction

    // Expected {carry, overflow, answer} for the operands carried by an LFSR word.
    function automatic logic [7:0] aluWord(input logic [11:0] v);
        int a, b, sa, sb, sum, ssum;
        a    = int'(v[11:6]);
        b    = int'(v[5:0]);
        sum  = a + b;
        sa   = (a >= 32) ? a - 64 : a;
        sb   = (b >= 32) ? b - 64 : b;
        ssum = sa + sb;
        return {(sum > 63) ? 1'b1 : 1'b0, (ssum > 31 || ssum < -32) ? 1'b1 : 1'b0, 6'(sum % 64)};
    endfunction

    function automatic logic [7:0] fold(input logic [7:0] s, input logic [7:0] w);
        logic [7:0] r;
        r = {s[6:0], s[7]};
        return r ^ w;
    endfunction

    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_x"}, 32'(x), 32'(6'h2B));
        checkOutput({tag, "_y"}, 32'(y), 32'(6'h0E));
        checkOutput({tag, "_fxn"}, 32'(fxn), 32'd0);
        checkOutput({tag, "_leds"}, 32'({led_carry, led_oflow, led_result}), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_sig"}, 32'(sig), 32'd0);
        checkOutput({tag, "_vec"}, 32'(vec_idx), 32'd0);
    endtask

    // Raise start on a negedge and return #1 after the edge that samples the rise.
    task automatic applyStimulus();
        @(negedge clk);
        start = 1'b1;
        #1;
        checkOutput("busy_before_rise", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Entered #1 after the rise edge; follows the whole run vector by vector.
    task automatic walkRun(output logic [7:0] finalSig);
        logic [11:0] l;
        logic [7:0]  s, w, prevW;
        l     = SEED;
        s     = 8'h00;
        w     = 8'h00;
        prevW = 8'h00;
        checkOutput("sig_cleared", 32'(sig), 32'd0);
        for (int k = 0; k < NV; k++) begin
            checkOutput("x", 32'(x), 32'(l[11:6]));
            checkOutput("y", 32'(y), 32'(l[5:0]));
            checkOutput("fxn", 32'(fxn), 32'(k % 8));
            checkOutput("vec_idx", 32'(vec_idx), 32'(k));
            checkOutput("busy", 32'(busy), 32'd1);
            if (k > 0) checkOutput("led_kept", 32'({led_carry, led_oflow, led_result}), 32'(prevW));
            waitEdges(S + 1);
            w = aluWord(l);
            s = fold(s, w);
            checkOutput("led_capture", 32'({led_carry, led_oflow, led_result}), 32'(w));
            checkOutput("sig_fold", 32'(sig), 32'(s));
            waitEdges(H);
            checkOutput("done_early", 32'(done), 32'd0);
            waitEdges(1);
            prevW = w;
            if (k < NV - 1) l = lfsrStep(l);
        end
        checkOutput("done_end", 32'(done), 32'd1);
        checkOutput("busy_end", 32'(busy), 32'd0);
        checkOutput("vec_end", 32'(vec_idx), 32'(NV - 1));
        checkOutput("x_end", 32'(x), 32'(l[11:6]));
        checkOutput("sig_end", 32'(sig), 32'(s));
        finalSig = s;
    endtask

    initial begin
        seedV = SEED;
        #1 rst_n = 1'b0;
        #2 checkReset("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        waitEdges(3);
        checkOutput("idle_busy", 32'(busy), 32'd0);

        // Run 1: start held ~200 cycles with a short dip mid-run (must be ignored).
        dipAt = $urandom_range(20, 50);
        fork
            begin
                @(posedge clk);
                repeat (dipAt) @(posedge clk);
                #2 start = 1'b0;
                @(posedge clk);
                #2 start = 1'b1;
                repeat (150) @(posedge clk);
                #2 start = 1'b0;
            end
        join_none
        applyStimulus();
        walkRun(sigRun1);

        checkOutput("nv1_done", 32'(done1), 32'd1);
        checkOutput("nv1_vec", 32'(vec_idx1), 32'd0);
        checkOutput("nv1_x", 32'(x1), 32'(seedV[11:6]));
        checkOutput("nv1_y", 32'(y1), 32'(seedV[5:0]));
        checkOutput("nv1_fxn", 32'(fxn1), 32'd0);
        checkOutput("nv1_led", 32'({led_carry1, led_oflow1, led_result1}), 32'(aluWord(seedV)));
        checkOutput("nv1_sig", 32'(sig1), 32'(fold(8'h00, aluWord(seedV))));

        waitEdges(160);
        checkOutput("held_done", 32'(done), 32'd1);
        checkOutput("held_vec", 32'(vec_idx), 32'(NV - 1));
        checkOutput("held_sig", 32'(sig), 32'(sigRun1));

        // Run 2: a fresh pulse after DONE must reproduce the same signature.
        pw = $urandom_range(0, 3);
        applyStimulus();
        fork
            begin
                repeat (pw) @(posedge clk);
                #2 start = 1'b0;
            end
        join_none
        walkRun(sigRun2);
        checkOutput("sig_rerun", 32'(sig), 32'(sigRun1));

        // Run 3: async reset asserted somewhere inside the second vector's HOLD.
        waitEdges(2);
        applyStimulus();
        #2 start = 1'b0;
        waitEdges(PERIOD + S + 1 + $urandom_range(0, H - 1));
        checkOutput("mid_hold_busy", 32'(busy), 32'd1);
        checkOutput("mid_hold_vec", 32'(vec_idx), 32'd1);
        #2 rst_n = 1'b0;
        #1 checkReset("midrun_reset");
        checkOutput("midrun_reset_done1", 32'(done1), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        waitEdges(3);
        checkOutput("post_reset_busy", 32'(busy), 32'd0);
        checkOutput("post_reset_x", 32'(x), 32'(6'h2B));

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
